seg7_scan_reader: RTL and testbench
===================================

# seg7_scan_reader

Recovers the hexadecimal value shown on a time-multiplexed 7-segment display by watching its digit strobes and segment lines. It is the reading end of our hex-to-segment display path and is used in loopback self-test and to monitor display buses driven from outside the design. Each settled digit pattern is decoded back to a nibble, and whole frames are assembled. Each complete, valid frame is presented on a valid/ready output.

## Interface
Parameters:
- DIGITS, 4: number of multiplexed digits (1..8).
- SETTLE, 4: consecutive identical synchronized segment samples required to capture a digit (≥1).

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- an  in  DIGITS  digit strobes, active-high; an[i] = digit i. Asynchronous to clk.
- seg  in  7  segment lines, active-high lit; seg[6]=A … seg[0]=G. Asynchronous to clk.
- out_value  out  4*DIGITS  assembled value; digit i occupies out_value[4i+3:4i].
- out_valid  out  1  out_value holds an unconsumed frame.
- out_ready  in  1  consumer accepts the frame when out_valid && out_ready.
- frame_err  out  1  one-cycle pulse: frame aborted or held an undecodable pattern.
- overrun  out  1  one-cycle pulse: an unconsumed frame was overwritten.

## Operation
- Two-flop synchronizer on an and seg. All logic below acts on the synchronized values (an_s, seg_s).
- Decode uses the standard hex font: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111 (order ABCDEFG). Any other pattern, including all-off, is invalid.
- State machine, with digit index idx, stability counter cnt, and per-frame bad flag:
  - HUNT: wait for an_s == onehot(0). Then go to SETTLE with idx=0, cnt=1, bad=0.
  - SETTLE: requires an_s == onehot(idx).
    - If seg_s equals the previous cycle's value, cnt increments; otherwise cnt=1.
    - When cnt reaches SETTLE, capture the decoded nibble into the staging register at slot idx. An invalid decode sets bad. Then go to HOLD.
    - If an_s changes before capture, pulse frame_err and go to HUNT.
  - HOLD: an_s == onehot(idx) or an_s == 0 (blanking) stays in HOLD.
    - If an_s == onehot(idx+1) and idx < DIGITS-1: go to SETTLE with idx+1, cnt=1.
    - If idx == DIGITS-1 and an_s leaves onehot(idx): go to HUNT. An_s == onehot(0) at that moment counts as a HUNT hit in the same cycle.
    - Any other an_s value (multi-hot, skipped digit, or backward digit): pulse frame_err and go to HUNT.
- Commit happens at capture of digit DIGITS-1:
  - If bad is clear (including the last digit), load out_value from staging and set out_valid.
  - If bad is set, pulse frame_err and do not touch the output.
- Output handshake:
  - out_valid clears on out_valid && out_ready unless a commit happens in the same cycle; commit wins and out_valid stays 1.
  - Commit while out_valid && !out_ready: overwrite out_value and pulse overrun.
  - out_value is stable while out_valid && !out_ready, apart from that overwrite.
- Reset mid-frame discards the staging register and all partial state.

## Timing
- Reset values: out_value=0, out_valid=0, frame_err=0, overrun=0, state=HUNT, synchronizers=0.
- Digit capture latency: 2 sync cycles plus SETTLE cycles after a raw digit strobe and stable seg.
- out_valid rises 1 cycle after the last digit's capture cycle.
- frame_err and overrun are registered, one-cycle pulses, asserted the cycle after the triggering condition.
- Minimum strobe width for capture: SETTLE+1 clk cycles (the extra cycle covers synchronizer skew).

## Structure
- Package seg7_pkg holds:
  - typedef seg7_t (logic [6:0]);
  - constant SEG7_FONT[16] of seg7_t;
  - enum scan_state_t {HUNT, SETTLE, HOLD}.
- Sub-module seg7_decode: combinational; input seg7_t; outputs nibble[3:0] and hit. It searches SEG7_FONT. It is the inverse of our display encoder and is reusable on its own.

## Test plan
- Scan digits 0..3 showing 1,2,3,4 (SETTLE=4, each strobe 10 cycles, out_ready=1) -> out_value=16'h4321, out_valid pulses for 1 cycle, no frame_err.
- Scan "F","E","d","C" with out_ready=0 -> out_value=16'hCDEF held; a second frame "0","0","0","8" -> out_value=16'h8000 and one overrun pulse.
- Digit 2 shows 0000001 (invalid) -> frame_err pulse at last capture; out_value keeps the previous frame; out_valid unchanged.
- Strobe order 0,1,3 -> frame_err pulse on the an_s==onehot(3) cycle; state HUNT; no commit.
- Segment glitch every 3 cycles while a digit strobe lasts 6 cycles -> no capture; frame_err when the strobe moves on.
- rst_n asserted asynchronously during digit 2 -> all outputs 0 immediately; the next full frame 9,A,b,C commits 16'hCBA9.

Source files
------------

// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment display path.
//   seg7_t       : segment vector, bit 6 = A ... bit 0 = G, active-high lit.
//   SEG7_FONT    : hex font, SEG7_FONT[n] is the pattern that displays nibble n.
//   scan_state_t : states of the scan reader's frame tracker.
// ---------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_FONT [16] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011,  // 9
        7'b1110111,  // A
        7'b0011111,  // b
        7'b1001110,  // C
        7'b0111101,  // d
        7'b1001111,  // E
        7'b1000111   // F
    };

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational inverse of the hex-to-segment encoder: looks the segment
// pattern up in SEG7_FONT.
//   seg_i    : segment pattern (A..G).
//   nibble_o : decoded hex digit, 0 when no font entry matches.
//   hit_o    : 1 when seg_i is exactly one of the 16 font patterns.
// ---------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  seg7_t      seg_i,
    output logic [3:0] nibble_o,
    output logic       hit_o
);

    // Font entries are all distinct, so at most one compare can match.
    always_comb begin
        nibble_o = 4'd0;
        hit_o    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG7_FONT[i]) begin
                nibble_o = 4'(i);
                hit_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// seg7_scan_reader
// Watches a time-multiplexed 7-segment display (digit strobes + segment
// lines, both asynchronous to clk), decodes each settled digit back to a
// nibble and assembles complete frames for a valid/ready consumer.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset.
//   an          : digit strobes, an[i] = digit i, active-high.
//   seg         : segment lines, seg[6]=A .. seg[0]=G, active-high.
//   out_value   : assembled frame, digit i in out_value[4i+3:4i].
//   out_valid   : out_value holds an unconsumed frame.
//   out_ready   : consumer accept.
//   frame_err   : one-cycle pulse, frame aborted or held an undecodable digit.
//   overrun     : one-cycle pulse, an unconsumed frame was overwritten.
//   dbg_state   : current frame-tracker state (scan_state_t encoding).
//
// Handshake: a frame transfers on a cycle where out_valid && out_ready.
// out_value does not change while out_valid && !out_ready except when a new
// frame commits over it (flagged by overrun). A commit in the same cycle as
// a transfer keeps out_valid high for the new frame.
// ---------------------------------------------------------------------------
module seg7_scan_reader #(
    parameter int DIGITS = 4,
    parameter int SETTLE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     an,
    input  logic [6:0]            seg,
    output logic [4*DIGITS-1:0]   out_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_err,
    output logic                  overrun,
    output logic [1:0]            dbg_state
);

    import seg7_pkg::*;

    // Counter only needs to reach SETTLE; one spare bit keeps +1 from wrapping.
    localparam int CNT_W = $clog2(SETTLE + 1) + 1;
    localparam logic [DIGITS-1:0] OH_ZERO = DIGITS'(1);

    // Synchronizers and previous-sample register.
    logic [DIGITS-1:0]   an_m_q, an_s_q;
    seg7_t               seg_m_q, seg_s_q, seg_prev_q;

    // Frame tracker.
    scan_state_t         state_q;
    logic [2:0]          idx_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                bad_q;
    logic [4*DIGITS-1:0] stage_q;

    // Registered outputs.
    logic [4*DIGITS-1:0] out_value_q;
    logic                out_valid_q;
    logic                frame_err_q;
    logic                overrun_q;

    // Decode of the synchronized segment lines.
    logic [3:0]          dec_nibble;
    logic                dec_hit;

    seg7_decode u_decode (
        .seg_i    (seg_s_q),
        .nibble_o (dec_nibble),
        .hit_o    (dec_hit)
    );

    // Combinational helpers for the tracker.
    logic [DIGITS-1:0]   oh_idx;
    logic [DIGITS-1:0]   oh_next;
    logic                last_digit;
    logic [CNT_W-1:0]    cnt_d;
    logic [4*DIGITS-1:0] stage_d;

    always_comb begin
        oh_idx  = '0;
        oh_next = '0;
        stage_d = stage_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                oh_idx[i]       = 1'b1;
                stage_d[4*i +: 4] = dec_nibble;
            end
            if ((i > 0) && (idx_q == 3'(i - 1))) begin
                oh_next[i] = 1'b1;
            end
        end
        last_digit = (idx_q == 3'(DIGITS - 1));
        // Stability run length including the current sample.
        cnt_d = (seg_s_q == seg_prev_q) ? cnt_q + CNT_W'(1) : CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_m_q      <= '0;
            an_s_q      <= '0;
            seg_m_q     <= '0;
            seg_s_q     <= '0;
            seg_prev_q  <= '0;
            state_q     <= seg7_pkg::HUNT;
            idx_q       <= '0;
            cnt_q       <= '0;
            bad_q       <= 1'b0;
            stage_q     <= '0;
            out_value_q <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            an_m_q     <= an;
            an_s_q     <= an_m_q;
            seg_m_q    <= seg;
            seg_s_q    <= seg_m_q;
            seg_prev_q <= seg_s_q;

            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            // Transfer; a commit below overrides this assignment.
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                seg7_pkg::HUNT: begin
                    if (an_s_q == OH_ZERO) begin
                        state_q <= seg7_pkg::SETTLE;
                        idx_q   <= '0;
                        cnt_q   <= CNT_W'(1);
                        bad_q   <= 1'b0;
                    end
                end

                seg7_pkg::SETTLE: begin
                    if (an_s_q != oh_idx) begin
                        frame_err_q <= 1'b1;
                        state_q     <= seg7_pkg::HUNT;
                    end else if (cnt_d >= CNT_W'(SETTLE)) begin
                        stage_q <= stage_d;
                        bad_q   <= bad_q | ~dec_hit;
                        state_q <= seg7_pkg::HOLD;
                        if (last_digit) begin
                            if (bad_q || !dec_hit) begin
                                frame_err_q <= 1'b1;
                            end else begin
                                out_value_q <= stage_d;
                                out_valid_q <= 1'b1;
                                overrun_q   <= out_valid_q && !out_ready;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                seg7_pkg::HOLD: begin
                    if ((an_s_q == oh_idx) || (an_s_q == '0)) begin
                        // Same digit still lit, or inter-digit blanking.
                        state_q <= seg7_pkg::HOLD;
                    end else if (last_digit) begin
                        // Frame finished; a strobe on digit 0 starts the next one now.
                        if (an_s_q == OH_ZERO) begin
                            state_q <= seg7_pkg::SETTLE;
                            idx_q   <= '0;
                            cnt_q   <= CNT_W'(1);
                            bad_q   <= 1'b0;
                        end else begin
                            state_q <= seg7_pkg::HUNT;
                        end
                    end else if (an_s_q == oh_next) begin
                        state_q <= seg7_pkg::SETTLE;
                        idx_q   <= idx_q + 3'd1;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= seg7_pkg::HUNT;
                    end
                end

                default: begin
                    state_q <= seg7_pkg::HUNT;
                end
            endcase
        end
    end

    assign out_value = out_value_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_reader
// Drives scanned display frames (directed cases, then random frames) into
// seg7_scan_reader. A frame-level model predicts, for each frame, whether it
// commits or errors, which committed values the consumer must receive (in
// order), and the running totals of frame_err and overrun pulses.
// ---------------------------------------------------------------------------
module tb_seg7_scan_reader;

    localparam int DIGITS = 4;
    localparam int SETTLE = 4;
    localparam int W      = 4 * DIGITS;

    localparam int K_OK     = 0;  // well-formed scan
    localparam int K_BADPAT = 1;  // well-formed scan, one digit shows a non-font pattern
    localparam int K_SKIP   = 2;  // strobe jumps over one digit
    localparam int K_GLITCH = 3;  // one digit's segments never settle

    // Hex font, ABCDEFG order.
    localparam logic [6:0] FONT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DIGITS-1:0] an = '0;
    logic [6:0]        seg = '0;
    logic              out_ready = 1'b0;
    logic [W-1:0]      out_value;
    logic              out_valid;
    logic              frame_err;
    logic              overrun;
    logic [1:0]        dbg_state;

    always #5 clk = ~clk;

    seg7_scan_reader #(
        .DIGITS (DIGITS),
        .SETTLE (SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .an        (an),
        .seg       (seg),
        .out_value (out_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int           n_chk = 0;
    int           n_fail = 0;
    int           fe_seen = 0;
    int           ov_seen = 0;
    int           extra_acc = 0;
    logic [W-1:0] exp_q[$];

    // Frame-level model state.
    bit           pend = 1'b0;
    logic [W-1:0] last_val = '0;
    int           fe_exp = 0;
    int           ov_exp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: counts pulses and checks every transferred frame in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) fe_seen++;
            if (overrun)   ov_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) extra_acc++;
                else chk("accepted_value", 32'(out_value), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic bit pat_valid(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (p == FONT[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int d, input logic [6:0] pat, input int width);
        an    = '0;
        an[d] = 1'b1;
        seg   = pat;
        repeat (width) tick();
    endtask

    task automatic blank(input int n);
        an  = '0;
        seg = '0;
        repeat (n) tick();
    endtask

    // Six-cycle strobe whose segments change every three cycles.
    task automatic glitch_strobe(input int d, input logic [6:0] pat);
        an    = '0;
        an[d] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            seg = (c < 3) ? pat : (pat ^ 7'b0000001);
            tick();
        end
    endtask

    task automatic run_frame(input int kind, input logic [W-1:0] value, input int pos,
                             input logic [6:0] bad_pat, input bit rdy);
        logic [6:0]   pats [DIGITS];
        bit           commit;
        bit           all_ok;
        for (int d = 0; d < DIGITS; d++) pats[d] = FONT[value[4*d +: 4]];
        if (kind == K_BADPAT) pats[pos] = bad_pat;

        all_ok = 1'b1;
        for (int d = 0; d < DIGITS; d++) if (!pat_valid(pats[d])) all_ok = 1'b0;
        commit = ((kind == K_OK) || (kind == K_BADPAT)) && all_ok;

        // A frame left pending is taken as soon as the consumer is ready.
        if (rdy && pend) begin
            exp_q.push_back(last_val);
            pend = 1'b0;
        end
        if (commit) begin
            if (rdy) begin
                exp_q.push_back(value);
            end else begin
                if (pend) ov_exp++;
                pend = 1'b1;
            end
            last_val = value;
        end else begin
            fe_exp++;
        end
        out_ready = rdy;

        if (kind == K_SKIP) begin
            for (int d = 0; d <= pos; d++) begin
                strobe(d, pats[d], int'($urandom_range(SETTLE + 1, SETTLE + 6)));
                blank(int'($urandom_range(0, 2)));
            end
            strobe(pos + 2, pats[pos + 2], int'($urandom_range(SETTLE + 1, SETTLE + 6)));
        end else begin
            for (int d = 0; d < DIGITS; d++) begin
                if ((kind == K_GLITCH) && (d == pos)) glitch_strobe(d, pats[d]);
                else strobe(d, pats[d], int'($urandom_range(SETTLE + 1, SETTLE + 6)));
                blank(int'($urandom_range(0, 2)));
            end
        end
        blank(8);

        chk("frame_err_total", 32'(fe_seen), 32'(fe_exp));
        chk("overrun_total", 32'(ov_seen), 32'(ov_exp));
        chk("out_valid", 32'(out_valid), 32'(pend));
        chk("out_value", 32'(out_value), 32'(last_val));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int           r;
        int           kind;
        int           pos;
        logic [6:0]   bp;
        logic [W-1:0] val;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        chk("reset_out_value", 32'(out_value), 32'(0));
        chk("reset_frame_err", 32'(frame_err), 32'(0));
        chk("reset_overrun", 32'(overrun), 32'(0));
        chk("reset_state", 32'(dbg_state), 32'(seg7_pkg::HUNT));
        @(negedge clk);
        rst_n = 1'b1;
        blank(4);

        // Directed frames.
        run_frame(K_OK,     16'h4321, 0, 7'd0, 1'b1);
        run_frame(K_OK,     16'hCDEF, 0, 7'd0, 1'b0);
        run_frame(K_OK,     16'h8000, 0, 7'd0, 1'b0);
        run_frame(K_BADPAT, 16'h1234, 2, 7'b0000001, 1'b0);
        run_frame(K_SKIP,   16'h5678, 1, 7'd0, 1'b0);
        run_frame(K_GLITCH, 16'h9ABC, 1, 7'd0, 1'b0);

        // Asynchronous reset during digit 2 while a frame is pending.
        chk("pre_reset_valid", 32'(out_valid), 32'(1));
        out_ready = 1'b0;
        strobe(0, FONT[5], 6);
        strobe(1, FONT[6], 6);
        an  = 4'b0100;
        seg = FONT[7];
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'(0));
        chk("midreset_out_value", 32'(out_value), 32'(0));
        chk("midreset_frame_err", 32'(frame_err), 32'(0));
        chk("midreset_overrun", 32'(overrun), 32'(0));
        chk("midreset_state", 32'(dbg_state), 32'(seg7_pkg::HUNT));
        pend     = 1'b0;
        last_val = '0;
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        blank(4);
        run_frame(K_OK, 16'hCBA9, 0, 7'd0, 1'b1);

        // Random frames.
        for (int f = 0; f < 30; f++) begin
            r = int'($urandom_range(0, 9));
            if (r == 6)      kind = K_BADPAT;
            else if (r == 7) kind = K_SKIP;
            else if (r == 8) kind = K_GLITCH;
            else             kind = K_OK;
            val = W'($urandom);
            pos = (kind == K_SKIP) ? int'($urandom_range(0, DIGITS - 3))
                                   : int'($urandom_range(0, DIGITS - 1));
            bp = 7'($urandom);
            while (pat_valid(bp)) bp = 7'($urandom);
            run_frame(kind, val, pos, bp, 1'($urandom_range(0, 1)));
        end

        // Drain anything still pending.
        if (pend) begin
            exp_q.push_back(last_val);
            pend = 1'b0;
        end
        out_ready = 1'b1;
        repeat (4) tick();
        chk("final_out_valid", 32'(out_valid), 32'(pend));
        chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
        chk("extra_accepts", 32'(extra_acc), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
